lattice_stream_out: RTL

LATTICE_STREAM_OUT -- requirements
Module: lattice_stream_out

---
 rtl/lattice_stream_out.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lattice_stream_out.sv
// lattice_stream_out: streams one frame of D2Q9 lattice nodes from a BRAM to
// an AXI4-Stream master. One beat carries all Q directions of one node.
// Reads are issued ahead of the stream into a small skid FIFO. The FIFO is
// sized so that every read in flight always has a slot when its data returns.
module lattice_stream_out #(
    parameter int DATA_WIDTH = 16,
    parameter int Q          = 9,
    parameter int DEPTH      = 2500,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                         m00_axis_aclk,
    input  logic                         m00_axis_areset,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic [Q*DATA_WIDTH-1:0]      rd_data,
    input  logic                         m00_axis_tready,
    output logic                         m00_axis_tvalid,
    output logic [Q*DATA_WIDTH-1:0]      m00_axis_tdata,
    output logic [Q*DATA_WIDTH/8-1:0]    m00_axis_tstrb,
    output logic                         m00_axis_tlast
);

    localparam int W          = Q * DATA_WIDTH;
    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] base_reg;
    logic [CNT_W-1:0]      rd_count;
    logic [CNT_W-1:0]      beat_count;
    logic [RD_LATENCY-1:0] in_flight;
    logic [W-1:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [OCC_W-1:0]      occupancy;
    logic                  accept;
    logic                  fifo_wr;
    logic                  fifo_pop;
    logic                  last_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state and all combinational outputs; reads are throttled so
    // buffered plus outstanding data never exceeds the FIFO capacity.
    always_comb begin
        int pending;
        state_next      = state;
        pending         = int'(occupancy) + $countones(in_flight);
        accept          = (state == IDLE) && start;
        busy            = (state != IDLE);
        rd_en           = (state == RUN) && (rd_count < DEPTH_CNT) && (pending < FIFO_DEPTH);
        rd_addr         = base_reg + ADDR_WIDTH'(rd_count);
        fifo_wr         = in_flight[RD_LATENCY-1];
        m00_axis_tvalid = (occupancy != '0);
        m00_axis_tdata  = m00_axis_tvalid ? fifo_mem[rd_ptr] : '0;
        m00_axis_tlast  = m00_axis_tvalid && (beat_count == LAST_IDX);
        m00_axis_tstrb  = '1;
        fifo_pop        = m00_axis_tvalid && m00_axis_tready;
        last_pop        = fifo_pop && (beat_count == LAST_IDX);
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (rd_en && (rd_count == LAST_IDX)) state_next = DRAIN;
            DRAIN:   if (last_pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, frame counters and the one-cycle done pulse.
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state      <= IDLE;
            base_reg   <= '0;
            rd_count   <= '0;
            beat_count <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == DRAIN) && last_pop;
            if (accept) begin
                base_reg   <= base_addr;
                rd_count   <= '0;
                beat_count <= '0;
            end else begin
                if (rd_en)    rd_count   <= rd_count + CNT_W'(1);
                if (fifo_pop) beat_count <= beat_count + CNT_W'(1);
            end
        end
    end

    // Tracks reads in flight so returning data is captured exactly RD_LATENCY
    // cycles after its read; clearing it on reset drops stale returns.
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            in_flight <= '0;
        end else begin
            in_flight[0] <= rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                in_flight[i] <= in_flight[i-1];
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous write and pop leave it unchanged.
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (fifo_wr)  wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
            if (fifo_wr && !fifo_pop) occupancy <= occupancy + OCC_W'(1);
            else if (!fifo_wr && fifo_pop) occupancy <= occupancy - OCC_W'(1);
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge m00_axis_aclk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= rd_data;
    end

endmodule
